ped_xing_ctrl: RTL and testbench

- Parametrised pedestrian-crossing controller; next generation of the board's fixed-timing car/pedestrian light.
- Adds a synchronised, debounced button with a latched request and a minimum car-green time.
- Adds all-red clearance phases, a flashing pedestrian-green warning phase, and a common prescaled tick so every duration is a parameter.
- Drives the car and pedestrian LEDs directly; LED polarity is selectable.

---
 rtl/ped_xing_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_ped_xing_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ped_xing_ctrl.sv
// ped_xing_ctrl: pedestrian-crossing controller.
// Synchronised and debounced request button with a latched request. Minimum car-green time.
// All-red clearance phases and a flashing pedestrian-green warning phase.
// Every duration counts ticks of a common prescaler.
// Optional build macro PED_COUNTDOWN_EN adds the ped_remain countdown output.
module ped_xing_ctrl #(
  parameter int TICK_DIV       = 12000000,
  parameter int DEB_CYCLES     = 120000,
  parameter int T_MIN_GREEN    = 4,
  parameter int T_YELLOW       = 3,
  parameter int T_ALL_RED      = 1,
  parameter int T_PED_GREEN    = 6,
  parameter int T_PED_FLASH    = 4,
  parameter int FLASH_HALF     = 1,
  parameter bit LED_ACTIVE_LOW = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       car_r,
  output logic       car_y,
  output logic       car_g,
  output logic       ped_r,
  output logic       ped_g,
  output logic       req_pending,
  output logic [2:0] state
`ifdef PED_COUNTDOWN_EN
  ,
  output logic [7:0] ped_remain
`endif
);

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int T_MAX = imax(imax(imax(T_MIN_GREEN, T_YELLOW), imax(T_ALL_RED, T_PED_GREEN)),
                              T_PED_FLASH);
  localparam int TW = $clog2(T_MAX + 1);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int FW = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_HALF - 1);

  typedef enum logic [2:0] {
    CAR_GREEN  = 3'd0,
    CAR_YELLOW = 3'd1,
    ALL_RED1   = 3'd2,
    PED_GREEN  = 3'd3,
    PED_FLASH  = 3'd4,
    ALL_RED2   = 3'd5
  } state_t;

  // Timer load value on entry to a state: duration minus one tick.
  function automatic logic [TW-1:0] load_of(input state_t s);
    case (s)
      CAR_YELLOW:         return TW'(T_YELLOW - 1);
      ALL_RED1, ALL_RED2: return TW'(T_ALL_RED - 1);
      PED_GREEN:          return TW'(T_PED_GREEN - 1);
      PED_FLASH:          return TW'(T_PED_FLASH - 1);
      default:            return TW'(T_MIN_GREEN - 1);
    endcase
  endfunction

  // Lamp pattern in lit-sense, packed as {car_r, car_y, car_g, ped_r, ped_g}.
  function automatic logic [4:0] lamps_of(input state_t s, input logic flash_on);
    case (s)
      CAR_GREEN:  return 5'b00110;
      CAR_YELLOW: return 5'b01010;
      PED_GREEN:  return 5'b10001;
      PED_FLASH:  return {4'b1000, flash_on};
      default:    return 5'b10010;
    endcase
  endfunction

  logic          sync1_reg, sync2_reg, filt_reg, filt_d_reg;
  logic [DW-1:0] deb_cnt_reg;
  logic          btn_rise;

  state_t        state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [TW-1:0] timer_reg, timer_next;
  logic          expired_reg, expired_next;
  logic [FW-1:0] flash_cnt_reg, flash_cnt_next;
  logic          flash_on_reg, flash_on_next;
  logic          req_reg, req_next;
  logic [4:0]    lamps_reg, lamps_next;
  logic          tick, done, change;

  // Button synchroniser and debouncer. The filtered level flips only after the
  // synced level has held the opposite value for DEB_CYCLES consecutive cycles.
  // The counter restarts whenever the synced level changes back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg   <= 1'b0;
      sync2_reg   <= 1'b0;
      filt_reg    <= 1'b0;
      filt_d_reg  <= 1'b0;
      deb_cnt_reg <= '0;
    end else begin
      sync1_reg  <= btn;
      sync2_reg  <= sync1_reg;
      filt_d_reg <= filt_reg;
      if (sync2_reg == filt_reg) begin
        deb_cnt_reg <= '0;
      end else if (deb_cnt_reg == DEB_LAST) begin
        filt_reg    <= sync2_reg;
        deb_cnt_reg <= '0;
      end else begin
        deb_cnt_reg <= deb_cnt_reg + DW'(1);
      end
    end
  end

  assign btn_rise = filt_reg & ~filt_d_reg;

  // Next-state, prescaler, phase timer, flash and request-latch logic.
  always_comb begin
    tick         = (presc_reg == PRESC_LAST);
    done         = tick && (timer_reg == '0);
    state_next   = state_reg;
    expired_next = expired_reg;
    case (state_reg)
      CAR_GREEN: begin
        if ((done || expired_reg) && req_reg) state_next = CAR_YELLOW;
        else if (done)                        expired_next = 1'b1;
      end
      CAR_YELLOW: if (done) state_next = ALL_RED1;
      ALL_RED1:   if (done) state_next = PED_GREEN;
      PED_GREEN:  if (done) state_next = PED_FLASH;
      PED_FLASH:  if (done) state_next = ALL_RED2;
      ALL_RED2:   if (done) state_next = CAR_GREEN;
      default:    state_next = CAR_GREEN;
    endcase

    change = (state_next != state_reg);
    if (change) begin
      // Every phase starts with a fresh prescaler so its length is exact.
      presc_next     = '0;
      timer_next     = load_of(state_next);
      expired_next   = 1'b0;
      flash_cnt_next = '0;
      flash_on_next  = 1'b1;
    end else begin
      presc_next     = tick ? '0 : presc_reg + PW'(1);
      timer_next     = (tick && timer_reg != '0) ? timer_reg - TW'(1) : timer_reg;
      flash_cnt_next = flash_cnt_reg;
      flash_on_next  = flash_on_reg;
      if (tick && state_reg == PED_FLASH) begin
        if (flash_cnt_reg == FLASH_LAST) begin
          flash_cnt_next = '0;
          flash_on_next  = ~flash_on_reg;
        end else begin
          flash_cnt_next = flash_cnt_reg + FW'(1);
        end
      end
    end

    // Entering PED_GREEN serves the request; presses while pedestrians walk are dropped.
    req_next = req_reg;
    if (change && state_next == PED_GREEN)
      req_next = 1'b0;
    else if (btn_rise && state_reg != PED_GREEN && state_reg != PED_FLASH)
      req_next = 1'b1;

    lamps_next = lamps_of(state_next, flash_on_next);
  end

  // FSM state register with registered lamp outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= CAR_GREEN;
      presc_reg     <= '0;
      timer_reg     <= TW'(T_MIN_GREEN - 1);
      expired_reg   <= 1'b0;
      flash_cnt_reg <= '0;
      flash_on_reg  <= 1'b1;
      req_reg       <= 1'b0;
      lamps_reg     <= 5'b00110;
    end else begin
      state_reg     <= state_next;
      presc_reg     <= presc_next;
      timer_reg     <= timer_next;
      expired_reg   <= expired_next;
      flash_cnt_reg <= flash_cnt_next;
      flash_on_reg  <= flash_on_next;
      req_reg       <= req_next;
      lamps_reg     <= lamps_next;
    end
  end

  assign {car_r, car_y, car_g, ped_r, ped_g} = lamps_reg ^ {5{LED_ACTIVE_LOW}};
  assign req_pending = req_reg;
  assign state       = state_reg;

`ifdef PED_COUNTDOWN_EN
  logic [7:0] remain_reg, remain_next;

  // Remaining pedestrian ticks across PED_GREEN and PED_FLASH; zero elsewhere.
  always_comb begin
    remain_next = '0;
    if (state_next == PED_GREEN && state_reg != PED_GREEN)
      remain_next = 8'(T_PED_GREEN + T_PED_FLASH);
    else if (state_next == PED_GREEN || state_next == PED_FLASH)
      remain_next = (tick && remain_reg != 8'd0) ? remain_reg - 8'd1 : remain_reg;
  end

  // Countdown register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) remain_reg <= '0;
    else        remain_reg <= remain_next;
  end

  assign ped_remain = remain_reg;
`endif

endmodule

// File: tb/tb_ped_xing_ctrl.sv
// Testbench for ped_xing_ctrl: a table of crossing checkpoints, hand-written corner sequences,
// and randomized button/reset stimulus. The stimulus is checked every cycle against a
// cycle-count reference model.
`timescale 1ns/1ps
module tb_ped_xing_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int DEB_CYCLES  = 3;
  localparam int T_MIN_GREEN = 5;
  localparam int T_YELLOW    = 3;
  localparam int T_ALL_RED   = 1;
  localparam int T_PED_GREEN = 4;
  localparam int T_PED_FLASH = 4;
  localparam int FLASH_HALF  = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn = 1'b0;
  logic car_r, car_y, car_g, ped_r, ped_g, req_pending;
  logic [2:0] state;
`ifdef PED_COUNTDOWN_EN
  logic [7:0] ped_remain;
`endif

  ped_xing_ctrl #(
    .TICK_DIV(TICK_DIV), .DEB_CYCLES(DEB_CYCLES), .T_MIN_GREEN(T_MIN_GREEN),
    .T_YELLOW(T_YELLOW), .T_ALL_RED(T_ALL_RED), .T_PED_GREEN(T_PED_GREEN),
    .T_PED_FLASH(T_PED_FLASH), .FLASH_HALF(FLASH_HALF), .LED_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn(btn),
    .car_r(car_r), .car_y(car_y), .car_g(car_g), .ped_r(ped_r), .ped_g(ped_g),
    .req_pending(req_pending), .state(state)
`ifdef PED_COUNTDOWN_EN
    , .ped_remain(ped_remain)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The phase is tracked as (state, cycles elapsed in it). The debouncer is a window of the
  // last DEB_CYCLES synced samples.
  int m_state, m_el;
  bit m_req, m_filt, m_filtp, m_s1, m_s2;
  bit m_run[$];

  function automatic int dur_cycles(input int s);
    case (s)
      0:       return T_MIN_GREEN * TICK_DIV;
      1:       return T_YELLOW * TICK_DIV;
      2, 5:    return T_ALL_RED * TICK_DIV;
      3:       return T_PED_GREEN * TICK_DIV;
      default: return T_PED_FLASH * TICK_DIV;
    endcase
  endfunction

  // {car_r, car_y, car_g, ped_r, ped_g}
  function automatic int exp_lamps(input int s, input int el);
    case (s)
      0:       return 5'b00110;
      1:       return 5'b01010;
      3:       return 5'b10001;
      4:       return (((el / TICK_DIV) / FLASH_HALF) % 2 == 0) ? 5'b10001 : 5'b10000;
      default: return 5'b10010;
    endcase
  endfunction

  function automatic int exp_remain(input int s, input int el);
    if (s == 3) return T_PED_GREEN + T_PED_FLASH - el / TICK_DIV;
    if (s == 4) return T_PED_FLASH - el / TICK_DIV;
    return 0;
  endfunction

  task automatic model_reset();
    m_state = 0; m_el = 0; m_req = 0; m_filt = 0; m_filtp = 0; m_s1 = 0; m_s2 = 0;
    m_run.delete();
  endtask

  task automatic model_edge(input bit b);
    int ns;
    bit rise, same;
    rise = m_filt && !m_filtp;
    m_filtp = m_filt;
    m_run.push_back(m_s2);
    if (m_run.size() > DEB_CYCLES) void'(m_run.pop_front());
    if (m_run.size() == DEB_CYCLES) begin
      same = 1;
      foreach (m_run[i]) if (m_run[i] != m_run[0]) same = 0;
      if (same && m_run[0] != m_filt) m_filt = m_run[0];
    end
    m_s2 = m_s1;
    m_s1 = b;
    ns = m_state;
    if (m_el >= dur_cycles(m_state) - 1) begin
      if (m_state != 0) ns = (m_state + 1) % 6;
      else if (m_req)   ns = 1;
    end
    if (ns == 3 && m_state != 3)                   m_req = 0;
    else if (rise && m_state != 3 && m_state != 4) m_req = 1;
    m_el = (ns != m_state) ? 0 : m_el + 1;
    m_state = ns;
  endtask

  task automatic compare_all(input string tag);
    check({tag, "_state"}, int'(state), m_state);
    check({tag, "_lamps"}, int'({car_r, car_y, car_g, ped_r, ped_g}), exp_lamps(m_state, m_el));
    check({tag, "_req"}, int'(req_pending), int'(m_req));
`ifdef PED_COUNTDOWN_EN
    check({tag, "_remain"}, int'(ped_remain), exp_remain(m_state, m_el));
`endif
  endtask

  // One clock with btn driven to b; DUT compared against the model 1 ns after the edge.
  task automatic step(input bit b);
    btn = b;
    @(posedge clk);
    model_edge(b);
    #1;
    compare_all("cyc");
  endtask

  // Asynchronous reset asserted between edges; outputs must change at once.
  task automatic do_reset(input int cycles);
    #2;
    rst_n = 1'b0;
    btn = 1'b0;
    model_reset();
    #1;
    compare_all("rst");
    repeat (cycles) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input int st, input bit b, input int budget, input string name);
    int k;
    k = 0;
    while (int'(state) != st && k < budget) begin
      step(b);
      k++;
    end
    check(name, int'(state), st);
  endtask

  typedef struct {
    bit b;
    int n;
    int st;
    int lamps;
    bit req;
  } vec_t;
  vec_t vecs[13];

  int  found, n, len;
  bit  lvl;

  initial begin
    // Hand-derived checkpoints of one crossing: btn high from cycle 3 on.
    vecs[0]  = '{1'b0,  2, 0, 5'b00110, 1'b0};
    vecs[1]  = '{1'b1,  5, 0, 5'b00110, 1'b0};
    vecs[2]  = '{1'b1,  1, 0, 5'b00110, 1'b1};
    vecs[3]  = '{1'b1, 11, 0, 5'b00110, 1'b1};
    vecs[4]  = '{1'b1,  1, 1, 5'b01010, 1'b1};
    vecs[5]  = '{1'b1, 11, 1, 5'b01010, 1'b1};
    vecs[6]  = '{1'b1,  1, 2, 5'b10010, 1'b1};
    vecs[7]  = '{1'b1,  4, 3, 5'b10001, 1'b0};
    vecs[8]  = '{1'b1, 16, 4, 5'b10001, 1'b0};
    vecs[9]  = '{1'b1,  4, 4, 5'b10000, 1'b0};
    vecs[10] = '{1'b1, 12, 5, 5'b10010, 1'b0};
    vecs[11] = '{1'b1,  4, 0, 5'b00110, 1'b0};
    vecs[12] = '{1'b0, 30, 0, 5'b00110, 1'b0};

    // Idle: no button, no crossing.
    do_reset(2);
    repeat (200) step(1'b0);
    check("idle_state", int'(state), 0);
    check("idle_req", int'(req_pending), 0);

    // Table-driven crossing.
    do_reset(1);
    foreach (vecs[i]) begin
      repeat (vecs[i].n) step(vecs[i].b);
      check($sformatf("vec%0d_state", i), int'(state), vecs[i].st);
      check($sformatf("vec%0d_lamps", i), int'({car_r, car_y, car_g, ped_r, ped_g}), vecs[i].lamps);
      check($sformatf("vec%0d_req", i), int'(req_pending), int'(vecs[i].req));
    end

    // Two-cycle glitch is filtered out.
    repeat (2) step(1'b1);
    repeat (20) step(1'b0);
    check("glitch_req", int'(req_pending), 0);
    check("glitch_state", int'(state), 0);

    // Press after min green expired: yellow on the cycle after req_pending rises.
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      step(1'b1);
      if (req_pending) found = 1;
    end
    check("pulse_req_seen", found, 1);
    check("pulse_state_at_req", int'(state), 0);
    step(1'b1);
    check("pulse_state_next", int'(state), 1);
    repeat (4) step(1'b1);

    // Press during PED_GREEN is ignored.
    wait_state(3, 1'b0, 60, "wait_st3");
    repeat (10) step(1'b1);
    wait_state(0, 1'b0, 60, "wait_st0_after_ped");
    check("ped_press_req", int'(req_pending), 0);
    repeat (40) step(1'b0);
    check("ped_press_state", int'(state), 0);

    // New crossing; flash pattern, then a request latched during ALL_RED2.
    repeat (8) step(1'b1);
    wait_state(4, 1'b0, 100, "wait_st4");
    for (int j = 0; j < 11; j++) begin
      step(1'b0);
      if (j == 1 || j == 5 || j == 9)
        check($sformatf("flash_el%0d", j + 1), int'(ped_g), (j == 5) ? 0 : 1);
    end
    repeat (8) step(1'b1);
    check("ar2_state", int'(state), 5);
    check("ar2_req", int'(req_pending), 1);
    wait_state(0, 1'b0, 10, "wait_st0_after_ar2");
    check("ar2_req_kept", int'(req_pending), 1);
    n = 0;
    while (int'(state) != 1 && n < 40) begin
      step(1'b0);
      n++;
    end
    check("recross_delay", n, 20);

    // Reset in the middle of PED_GREEN.
    wait_state(3, 1'b0, 60, "wait_st3_rst");
    repeat (5) step(1'b0);
    do_reset(1);
    check("midrst_state", int'(state), 0);
    check("midrst_car_g", int'(car_g), 1);
    check("midrst_req", int'(req_pending), 0);

    // Randomized button runs with occasional resets, checked against the model.
    for (int r = 0; r < 3000; r += len) begin
      lvl = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 30);
      if ($urandom_range(0, 60) == 0) do_reset($urandom_range(1, 2));
      for (int j = 0; j < len; j++) step(lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
